// File: rtl/full_adder_if.sv
// Operand/result bundle for the full_adder leaf cell.
// The master side drives the operands; the slave side (the adder) returns the sum and carry.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output a, b, cin,
        input  s, cout
    );

    modport slave (
        input  a, b, cin,
        output s, cout
    );
endinterface

// File: rtl/full_adder.sv
// Ripple-carry full adder built from two half-adder cells per bit slice.
// The sum and carry are either registered (REG_OUT=1) or driven straight from the ripple chain.
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1
) (
    input logic         clk,
    input logic         rst,
    full_adder_if.slave bus
);

    // Returns {carry, sum}. Plain gates, so X/Z propagate naturally.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH:0]   c;

    assign c[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign {g[i], p[i]}     = half_add(bus.a[i], bus.b[i]);
        assign {t[i], sum_c[i]} = half_add(p[i], c[i]);
        assign c[i+1]           = g[i] | t[i];
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] s_q;
        logic             cout_q;

        // Output register stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q    <= '0;
                cout_q <= 1'b0;
            end else begin
                s_q    <= sum_c;
                cout_q <= c[WIDTH];
            end
        end

        assign bus.s    = s_q;
        assign bus.cout = cout_q;
    end else begin : g_comb
        assign bus.s    = sum_c;
        assign bus.cout = c[WIDTH];
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: 1-bit registered, 4-bit registered and 1-bit combinational builds.
module tb_full_adder;

    logic clk;
    logic rst;
    logic clk_en;

    int n_vec;
    int n_err;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(4)) if4 ();
    full_adder_if #(.WIDTH(1)) ifc ();

    full_adder #(.WIDTH(1), .REG_OUT(1)) u_w1 (.clk(clk), .rst(rst), .bus(if1.slave));
    full_adder #(.WIDTH(4), .REG_OUT(1)) u_w4 (.clk(clk), .rst(rst), .bus(if4.slave));
    full_adder #(.WIDTH(1), .REG_OUT(0)) u_cb (.clk(clk), .rst(rst), .bus(ifc.slave));

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Truth table columns indexed by {a,b,cin}
    logic [7:0] tt_s;
    logic [7:0] tt_c;

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (if1.s !== 1'b0 || if1.cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_w1: got s=%b cout=%b, want s=0 cout=0", if1.s, if1.cout);
        end
        n_vec++;
        if (if4.s !== 4'h0 || if4.cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_w4: got s=%h cout=%b, want s=0 cout=0", if4.s, if4.cout);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_truth_table;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            @(negedge clk);
            {if1.a, if1.b, if1.cin} = v;
            @(posedge clk);
            #1;
            n_vec++;
            if (if1.s !== tt_s[i] || if1.cout !== tt_c[i]) begin
                n_err++;
                $display("FAIL truth_%b: got s=%b cout=%b, want s=%b cout=%b",
                         v, if1.s, if1.cout, tt_s[i], tt_c[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        {if1.a, if1.b, if1.cin} = 3'b111;
        @(posedge clk);
        #1;
        n_vec++;
        if (if1.s !== 1'b1 || if1.cout !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre: got s=%b cout=%b, want s=1 cout=1", if1.s, if1.cout);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (if1.s !== 1'b0 || if1.cout !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_async: got s=%b cout=%b, want s=0 cout=0", if1.s, if1.cout);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (if1.s !== 1'b0 || if1.cout !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_hold: got s=%b cout=%b, want s=0 cout=0", if1.s, if1.cout);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (if1.s !== 1'b1 || if1.cout !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_release: got s=%b cout=%b, want s=1 cout=1", if1.s, if1.cout);
        end
    endtask

    task automatic test_latency;
        {if1.a, if1.b, if1.cin} = 3'b000;
        @(posedge clk);
        #1;
        n_vec++;
        if (if1.s !== 1'b0 || if1.cout !== 1'b0) begin
            n_err++;
            $display("FAIL lat_zero: got s=%b cout=%b, want s=0 cout=0", if1.s, if1.cout);
        end
        {if1.a, if1.b, if1.cin} = 3'b110;
        #3;
        n_vec++;
        if (if1.s !== 1'b0 || if1.cout !== 1'b0) begin
            n_err++;
            $display("FAIL lat_before_edge: got s=%b cout=%b, want s=0 cout=0", if1.s, if1.cout);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (if1.s !== 1'b0 || if1.cout !== 1'b1) begin
            n_err++;
            $display("FAIL lat_after_edge: got s=%b cout=%b, want s=0 cout=1", if1.s, if1.cout);
        end
    endtask

    task automatic test_wrap;
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic       vc [3];
        logic [3:0] es [3];
        logic       ec [3];
        va = '{4'hF, 4'hF, 4'h5};
        vb = '{4'h0, 4'hF, 4'h3};
        vc = '{1'b1, 1'b1, 1'b0};
        es = '{4'h0, 4'hF, 4'h8};
        ec = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if4.a   = va[i];
            if4.b   = vb[i];
            if4.cin = vc[i];
            @(posedge clk);
            #1;
            n_vec++;
            if (if4.s !== es[i] || if4.cout !== ec[i]) begin
                n_err++;
                $display("FAIL wrap_%0d: got s=%h cout=%b, want s=%h cout=%b",
                         i, if4.s, if4.cout, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 1000; i++) begin
            logic [4:0] exp;
            if4.a   = 4'($urandom_range(0, 15));
            if4.b   = 4'($urandom_range(0, 15));
            if4.cin = 1'($urandom_range(0, 1));
            exp = 5'(if4.a) + 5'(if4.b) + 5'(if4.cin);
            @(posedge clk);
            #1;
            n_vec++;
            if ({if4.cout, if4.s} !== exp) begin
                n_err++;
                $display("FAIL b2b_%0d: got %h, want %h", i, {if4.cout, if4.s}, exp);
            end
        end
    endtask

    task automatic test_comb;
        @(negedge clk);
        clk_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {ifc.a, ifc.b, ifc.cin} = v;
            #50;
            n_vec++;
            if (ifc.s !== tt_s[i] || ifc.cout !== tt_c[i]) begin
                n_err++;
                $display("FAIL comb_%b: got s=%b cout=%b, want s=%b cout=%b",
                         v, ifc.s, ifc.cout, tt_s[i], tt_c[i]);
            end
            #50;
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        clk    = 1'b0;
        clk_en = 1'b1;
        rst    = 1'b0;
        tt_s   = 8'b1001_0110;
        tt_c   = 8'b1110_1000;

        test_reset();
        test_truth_table();
        test_reset_mid();
        test_latency();
        test_wrap();
        test_back_to_back();
        test_comb();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
